// File: rtl/mmio_led_bank_ctrl_pkg.sv
// Shared constants for the MMIO LED bank controller: display modes, register
// offsets relative to BASE_ADDR, and the IO data width.
package mmio_led_bank_ctrl_pkg;

    localparam int IO_W = 16;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_PWM    = 2'b10,
        MODE_OFF    = 2'b11
    } mode_t;

    // Control registers sit directly after the per-bank DATA registers.
    function automatic int off_mode(input int nb);
        return 4 * nb;
    endfunction

    function automatic int off_blink(input int nb);
        return 4 * nb + 4;
    endfunction

    function automatic int off_duty(input int nb);
        return 4 * nb + 8;
    endfunction

endpackage

// File: rtl/mmio_led_bank_ctrl_led_timebase.sv
// Shared timebase: tick prescaler, blink half-period counter/phase and the
// free-running PWM counter used by every bank.
module mmio_led_bank_ctrl_led_timebase #(
    parameter int TICK_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] blink_div,
    input  logic        blink_div_wr,
    input  logic [7:0]  pwm_duty,
    output logic        blink_phase,
    output logic        pwm_on
);

    logic        tick;
    logic [15:0] blink_cnt;
    logic [7:0]  pwm_cnt;

    generate
        if (TICK_DIV <= 1) begin : g_tick_const
            assign tick = 1'b1;
        end else begin : g_prescale
            localparam int PW = $clog2(TICK_DIV);
            logic [PW-1:0] pre;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    pre <= '0;
                else if (pre == PW'(TICK_DIV - 1))
                    pre <= '0;
                else
                    pre <= pre + PW'(1);
            end

            assign tick = (pre == PW'(TICK_DIV - 1));
        end
    endgenerate

    // A BLINK_DIV write restarts the pattern at the lit phase; a zero
    // divider parks the blink banks permanently lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_div_wr || blink_div == 16'd0) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (tick) begin
            if (blink_cnt == blink_div - 16'd1) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 8'd1;
    end

    assign pwm_on = (pwm_cnt < pwm_duty);

endmodule

// File: rtl/mmio_led_bank_ctrl.sv
// Memory-mapped LED controller: NUM_BANKS 8-bit banks, each static, blinking,
// PWM-dimmed or off, with registered read data and registered LED drive.
module mmio_led_bank_ctrl
    import mmio_led_bank_ctrl_pkg::*;
#(
    parameter int                NUM_BANKS = 3,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h60,
    parameter int                TICK_DIV  = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [IO_W-1:0]        wr_data,
    output logic [IO_W-1:0]        rd_data,
    output logic [8*NUM_BANKS-1:0] led_out
);

    localparam logic [ADDR_W-1:0] A_MODE  = ADDR_W'(off_mode(NUM_BANKS));
    localparam logic [ADDR_W-1:0] A_BLINK = ADDR_W'(off_blink(NUM_BANKS));
    localparam logic [ADDR_W-1:0] A_DUTY  = ADDR_W'(off_duty(NUM_BANKS));

    logic [NUM_BANKS-1:0][7:0] data;
    logic [2*NUM_BANKS-1:0]    mode;
    logic [15:0]               blink_div;
    logic [7:0]                pwm_duty;

    logic [ADDR_W-1:0]    off;
    logic                 in_win;
    logic [NUM_BANKS-1:0] sel_data;
    logic                 sel_mode;
    logic                 sel_blink;
    logic                 sel_duty;

    // Addresses below BASE_ADDR wrap to large offsets; in_win rejects them.
    assign off       = addr - BASE_ADDR;
    assign in_win    = (addr >= BASE_ADDR);
    assign sel_mode  = in_win && (off == A_MODE);
    assign sel_blink = in_win && (off == A_BLINK);
    assign sel_duty  = in_win && (off == A_DUTY);

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_sel
        assign sel_data[i] = in_win && (off == ADDR_W'(4 * i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= '0;
            mode      <= '0;
            blink_div <= '0;
            pwm_duty  <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BANKS; i++)
                if (sel_data[i]) data[i] <= wr_data[7:0];
            if (sel_mode)  mode      <= wr_data[2*NUM_BANKS-1:0];
            if (sel_blink) blink_div <= wr_data;
            if (sel_duty)  pwm_duty  <= wr_data[7:0];
        end
    end

    logic [IO_W-1:0] rd_next;

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            if (sel_data[i]) rd_next = IO_W'(data[i]);
        if (sel_mode)  rd_next = IO_W'(mode);
        if (sel_blink) rd_next = blink_div;
        if (sel_duty)  rd_next = IO_W'(pwm_duty);
    end

    // Registered from pre-write state, so a same-cycle write is not visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= rd_next;
    end

    logic blink_phase;
    logic pwm_on;

    mmio_led_bank_ctrl_led_timebase #(
        .TICK_DIV (TICK_DIV)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .blink_div    (blink_div),
        .blink_div_wr (wr_en && sel_blink),
        .pwm_duty     (pwm_duty),
        .blink_phase  (blink_phase),
        .pwm_on       (pwm_on)
    );

    logic [NUM_BANKS-1:0][7:0] led_next;

    always_comb begin
        led_next = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            case (mode[2*b +: 2])
                MODE_STATIC: led_next[b] = data[b];
                MODE_BLINK:  led_next[b] = data[b] & {8{blink_phase}};
                MODE_PWM:    led_next[b] = data[b] & {8{pwm_on}};
                default:     led_next[b] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            led_out <= '0;
        else
            led_out <= led_next;
    end

endmodule

// File: tb/tb_mmio_led_bank_ctrl.sv
// Self-checking bench: write vector table, read scoreboard, and hand-written
// blink / PWM / reset sequences for NUM_BANKS=3, TICK_DIV=2.
module tb_mmio_led_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic [23:0] led_out;

    int checks = 0;
    int failures = 0;

    logic [15:0] rd_q[$];
    logic        rd_pend = 1'b0;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        logic [23:0] exp_led;
    } wvec_t;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] exp_rd;
    } rvec_t;

    wvec_t wtab[11];
    rvec_t rtab[9];

    mmio_led_bank_ctrl #(
        .NUM_BANKS (3),
        .ADDR_W    (8),
        .BASE_ADDR (8'h60),
        .TICK_DIV  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Read scoreboard: a read issued at edge N is compared at the next negedge.
    always @(posedge clk or posedge rst) begin
        if (rst) rd_pend <= 1'b0;
        else     rd_pend <= rd_en;
    end

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else                  chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end
    end

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk); addr = a; wr_data = d; wr_en = 1'b1;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] e);
        @(negedge clk); addr = a; rd_en = 1'b1; rd_q.push_back(e);
        @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (rd_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rd_drain", 32'(rd_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] prev_led;
        logic [7:0]  prev_b0;
        int last_chg, nchg, bad, cnt, k;

        wtab[0]  = '{8'h60, 16'h00A5, 24'h0000A5};
        wtab[1]  = '{8'h64, 16'h003C, 24'h003CA5};
        wtab[2]  = '{8'h68, 16'h00FF, 24'hFF3CA5};
        wtab[3]  = '{8'h7C, 16'h0055, 24'hFF3CA5};
        wtab[4]  = '{8'h6C, 16'h003F, 24'h000000};
        wtab[5]  = '{8'h6C, 16'h0030, 24'h003CA5};
        wtab[6]  = '{8'h6C, 16'h0000, 24'hFF3CA5};
        wtab[7]  = '{8'h60, 16'hAB5A, 24'hFF3C5A};
        wtab[8]  = '{8'h60, 16'h00A5, 24'hFF3CA5};
        wtab[9]  = '{8'h74, 16'h1240, 24'hFF3CA5};
        wtab[10] = '{8'h70, 16'hBEEF, 24'hFF3CA5};

        rtab[0] = '{8'h7C, 16'h0000};
        rtab[1] = '{8'h5C, 16'h0000};
        rtab[2] = '{8'h78, 16'h0000};
        rtab[3] = '{8'h6C, 16'h0000};
        rtab[4] = '{8'h70, 16'hBEEF};
        rtab[5] = '{8'h74, 16'h0040};
        rtab[6] = '{8'h60, 16'h00A5};
        rtab[7] = '{8'h64, 16'h003C};
        rtab[8] = '{8'h68, 16'h00FF};

        repeat (3) @(negedge clk);
        chk("reset_led", 32'(led_out), 32'h0);
        chk("reset_rd", 32'(rd_data), 32'h0);
        rst = 1'b0;

        // Each write: unchanged right after the write edge, updated one cycle later.
        prev_led = 24'h0;
        for (int i = 0; i < 11; i++) begin
            wr(wtab[i].a, wtab[i].d);
            chk("wr_latency", 32'(led_out), 32'(prev_led));
            @(negedge clk);
            chk("wr_led", 32'(led_out), 32'(wtab[i].exp_led));
            prev_led = wtab[i].exp_led;
        end

        for (int i = 0; i < 9; i++) rd(rtab[i].a, rtab[i].exp_rd);
        drain();
        repeat (3) @(negedge clk);
        chk("rd_hold", 32'(rd_data), 32'h00FF);

        // Same-cycle write and read of bank0 returns the old value.
        @(negedge clk);
        addr = 8'h60; wr_data = 16'h0011; wr_en = 1'b1; rd_en = 1'b1;
        rd_q.push_back(16'h00A5);
        @(negedge clk); wr_en = 1'b0; rd_en = 1'b0;
        drain();
        rd(8'h60, 16'h0011);
        drain();
        chk("rw_led", 32'(led_out), 32'hFF3C11);
        wr(8'h60, 16'h00A5);

        // Blink: tick every 2 clk, half-period 3 ticks -> 6 clk per phase.
        wr(8'h70, 16'd3);
        wr(8'h6C, 16'h0001);
        prev_b0 = led_out[7:0];
        last_chg = -1; nchg = 0; bad = 0;
        for (int s = 0; s < 60; s++) begin
            @(negedge clk);
            if (led_out[7:0] !== prev_b0) begin
                if (last_chg >= 0) chk("blink_half_period", 32'(s - last_chg), 32'd6);
                last_chg = s;
                nchg++;
                prev_b0 = led_out[7:0];
            end
            if (led_out[7:0] !== 8'hA5 && led_out[7:0] !== 8'h00) bad++;
            if (led_out[23:8] !== 16'hFF3C) bad++;
        end
        chk("blink_toggles", 32'(nchg >= 8), 32'd1);
        chk("blink_values", 32'(bad), 32'd0);

        // Catch the dark phase, then rewrite BLINK_DIV: pattern restarts lit.
        k = 0;
        while (led_out[7:0] !== 8'h00 && k < 20) begin @(negedge clk); k++; end
        chk("blink_dark_found", 32'(led_out[7:0]), 32'h00);
        wr(8'h70, 16'd3);
        cnt = 0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (led_out[7:0] === 8'hA5) cnt++;
        end
        chk("blink_restart", 32'(cnt), 32'd5);

        wr(8'h70, 16'd0);
        @(negedge clk);
        cnt = 0;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (led_out === 24'hFF3CA5) cnt++;
        end
        chk("blink_div0", 32'(cnt), 32'd20);

        // PWM on bank1 with DATA=FF: lit cycles per 256 equal the duty.
        wr(8'h6C, 16'h0000);
        wr(8'h64, 16'h00FF);
        wr(8'h74, 16'd64);
        wr(8'h6C, 16'h0008);
        for (int d = 0; d < 3; d++) begin
            if (d == 1) wr(8'h74, 16'd0);
            if (d == 2) wr(8'h74, 16'd255);
            repeat (2) @(negedge clk);
            cnt = 0; bad = 0;
            for (int s = 0; s < 256; s++) begin
                @(negedge clk);
                if (led_out[15:8] === 8'hFF) cnt++;
                else if (led_out[15:8] !== 8'h00) bad++;
                if (led_out[7:0] !== 8'hA5 || led_out[23:16] !== 8'hFF) bad++;
            end
            chk("pwm_on_cycles", 32'(cnt), (d == 0) ? 32'd64 : (d == 1) ? 32'd0 : 32'd255);
            chk("pwm_values", 32'(bad), 32'd0);
        end

        // Asynchronous reset while blinking.
        wr(8'h70, 16'd3);
        wr(8'h6C, 16'h0001);
        repeat (8) @(negedge clk);
        rd(8'h60, 16'h00A5);
        drain();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led_out), 32'h0);
        chk("async_rst_rd", 32'(rd_data), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(8'h60, 16'h0000);
        rd(8'h64, 16'h0000);
        rd(8'h68, 16'h0000);
        rd(8'h6C, 16'h0000);
        rd(8'h70, 16'h0000);
        rd(8'h74, 16'h0000);
        drain();
        chk("post_rst_led", 32'(led_out), 32'h0);
        wr(8'h64, 16'h005A);
        chk("post_rst_latency", 32'(led_out), 32'h0);
        @(negedge clk);
        chk("post_rst_static", 32'(led_out), 32'h005A00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_led_bank_ctrl.md
Name: mmio_led_bank_ctrl

Overview:
Memory-mapped LED output controller for the CPU IO space, generalising the fixed 24-LED byte-lane writer to NUM_BANKS 8-bit banks. Each bank has its own display mode: static, blink, PWM-dimmed or off. Blink and PWM share one global timebase. Sits on the CPU IO bus beside the other MMIO peripherals and drives the board LED pins through a registered output.

Parameters:
NUM_BANKS, 3, number of 8-bit LED banks (1..8)
ADDR_W, 8, IO address width
BASE_ADDR, 8'h60, address of bank 0 data register
TICK_DIV, 1000, clk cycles per timebase tick (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset
wr_en  in  1  IO write strobe, one cycle per access
rd_en  in  1  IO read strobe, one cycle per access
addr  in  ADDR_W  IO byte address, word aligned
wr_data  in  16  write data
rd_data  out  16  read data, valid one cycle after rd_en
led_out  out  8*NUM_BANKS  LED drive; bank i is bits [8i+7:8i]

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. All of the following clear to 0 on reset: registers, counters, rd_data and led_out. blink_phase resets to 1.
- Register map, stride 4, offsets from BASE_ADDR:
  - 4*i, for i < NUM_BANKS: DATA[i], 8 bits, written from wr_data[7:0].
  - 4*NUM_BANKS: MODE, 2 bits per bank, bank i at [2i+1:2i]. Encodings: 00 static, 01 blink, 10 pwm, 11 off.
  - 4*NUM_BANKS+4: BLINK_DIV, 16 bits, half-period in ticks.
  - 4*NUM_BANKS+8: PWM_DUTY, 8 bits.
- Writes take effect at the clk edge where wr_en is high. Unmapped addresses are ignored. Unused upper wr_data bits are ignored.
- Reads: rd_data is registered one cycle after rd_en, zero-extended. Unmapped addresses return 0. rd_data holds its value until the next rd_en.
- Read and write to the same address in the same cycle: the read returns the pre-write value.
- Timebase:
  - prescale counter runs 0..TICK_DIV-1 and pulses tick for one cycle on wrap.
  - TICK_DIV=1 makes tick permanently high.
- Blink:
  - blink_cnt increments on each tick.
  - When blink_cnt == BLINK_DIV-1 on a tick: blink_cnt goes to 0 and blink_phase toggles.
  - BLINK_DIV == 0: blink_cnt held at 0, blink_phase forced to 1, so blink banks show DATA.
  - Any write to BLINK_DIV clears blink_cnt and sets blink_phase=1 on the same edge.
- PWM:
  - 8-bit pwm_cnt increments every clk and wraps 255->0.
  - pwm_on = (pwm_cnt < PWM_DUTY).
  - Duty 0 is always dark; duty 255 is on 255 of 256 cycles.
- Output, registered one cycle after internal state. Per bank:
  - static: DATA
  - blink: DATA & {8{blink_phase}}
  - pwm: DATA & {8{pwm_on}}
  - off: 0
- A DATA or MODE write appears on led_out exactly one cycle after the write edge.
- Reset mid-operation: counters, registers and outputs return to reset values immediately, with no glitch beyond the asynchronous clear.

Decomposition:
- Shared package holds:
  - mode encodings MODE_STATIC/MODE_BLINK/MODE_PWM/MODE_OFF
  - register offset constants OFF_MODE/OFF_BLINK/OFF_DUTY as functions of NUM_BANKS
  - IO data width 16
- One sub-module, led_timebase: prescaler, blink counter/phase and PWM counter.
  - Inputs: BLINK_DIV, blink_div_wr, PWM_DUTY.
  - Outputs: blink_phase, pwm_on.
- Register file, read mux and output mux stay in the top module.

Test Plan:
- Reset, then write 8'hA5 to 0x60, 8'h3C to 0x64 and 8'hFF to 0x68 (NUM_BANKS=3) -> one cycle after each write, led_out reaches 24'hFF3CA5. Reading 0x64 returns 16'h003C.
- TICK_DIV=2, BLINK_DIV=3, MODE=6'b000001 with bank0=8'hA5 -> bank0 alternates 8'hA5 and 8'h00 every 6 clk. Banks 1 and 2 stay static.
- PWM_DUTY=64 with bank1 in pwm mode and DATA=8'hFF -> over 256 cycles, bank1 is 8'hFF for exactly 64 cycles. Duty 0 gives 0 cycles.
- Write to unmapped 0x7C and read 0x7C -> led_out unchanged, rd_data=0. Simultaneous write 8'h11 and read of 0x60 returns the old value.
- BLINK_DIV=0 in blink mode -> bank shows DATA constantly. A mid-period rewrite of BLINK_DIV restarts the phase at 1.
- Assert rst while blinking -> led_out=0 and registers=0 asynchronously. After release, all banks are static with DATA=0.
